// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 16x oversampling UART receiver, 8N1 framing into a valid/ready stream.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx_deframer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_deframer: CLK_HZ/(BAUD*16) must be >= 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_deframer: DATA_BITS must be 5..9");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [PW-1:0]        presc;
  logic [3:0]           samp_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick, bit_tick;
  logic                 clr_all, clr_samp, shift_en, done, par_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Prescaler idles at zero so the first tick lands a fixed distance from the start edge.
  assign tick     = (state != S_IDLE) && (presc == PW'(DIV - 1));
  assign bit_tick = tick && (samp_cnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (state == S_IDLE || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en;
  logic par_bit;
`endif

  always_comb begin
    state_next = state;
    clr_all    = 1'b0;
    clr_samp   = 1'b0;
    shift_en   = 1'b0;
    done       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          clr_all    = 1'b1;
        end
      end
      S_START: begin
        if (tick && samp_cnt == 4'd7) begin
          if (rx_s) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
            clr_samp   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      if (clr_all || clr_samp) begin
        samp_cnt <= '0;
      end else if (tick) begin
        samp_cnt <= samp_cnt + 1'b1;
      end
      if (clr_all) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        shift <= {rx_s, shift[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (par_en) begin
      par_bit <= rx_s;
    end
  end
  assign par_bad = par_bit ^ (^shift);
`else
  assign par_bad = 1'b0;
`endif

  // Error checks are prioritised so at most one pulse fires and never alongside a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (done) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (par_bad) begin
          parity_err <= 1'b1;
        end else if (!m_valid || m_ready) begin
          m_data  <= shift;
          m_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - scoreboard bench for uart_rx_deframer at 16 clk per bit.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  int n_perr   = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .CLK_HZ(16_000_000),
    .BAUD(1_000_000),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .parity_err(parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    tick(16);
`endif
    rx = stop_bit;
    tick(16);
    rx = 1'b1;
  endtask

  // Error pulses are counted per cycle, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (parity_err) n_perr++;
      if (m_valid && m_ready) begin
        n_acc++;
        if (sb.size() == 0) check("sb_unexpected", sb.size(), 1);
        else check("sb_data", m_data, sb.pop_front());
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    tick(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    rst = 1'b0;
    tick(20);

    m_ready = 1'b1;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(20);
    check("t1_acc", n_acc, 1);
    check("t1_ferr", n_ferr, 0);
    check("t1_ovr", n_ovr, 0);
    check("t1_valid_low", m_valid, 0);

    m_ready = 1'b0;
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(4);
    check("t2_valid_held", m_valid, 1);
    check("t2_data_held", m_data, 8'h3C);
    check("t2_ovr", n_ovr, 1);
    m_ready = 1'b1;
    tick(3);
    check("t2_acc", n_acc, 2);
    check("t2_data_after", m_data, 8'h3C);
    check("t2_valid_low", m_valid, 0);

    send_frame(8'h55, 1'b0, 1'b0);
    tick(30);
    check("t3_ferr", n_ferr, 1);
    check("t3_no_valid", n_acc, 2);
    sb.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    tick(20);
    check("t3_acc_next", n_acc, 3);
    check("t3_ferr_once", n_ferr, 1);

    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check("t4_no_valid", n_acc, 3);
    check("t4_ferr", n_ferr, 1);
    check("t4_ovr", n_ovr, 1);
    check("t4_perr", n_perr, 0);
    sb.push_back(8'h69);
    send_frame(8'h69, 1'b1, 1'b0);
    tick(20);
    check("t4_acc_next", n_acc, 4);

    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(40);
    rst = 1'b1;
    #2;
    check("t5_m_valid", m_valid, 0);
    check("t5_m_data", m_data, 0);
    check("t5_errs", {frame_err, overrun, parity_err}, 0);
    tick(1);
    rst = 1'b0;
    tick(200);
    check("t5_dropped", n_acc, 4);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(20);
    check("t5_acc_next", n_acc, 5);

`ifdef UART_RX_PARITY_EN
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    tick(20);
    check("t6_good_acc", n_acc, 6);
    check("t6_good_perr", n_perr, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(20);
    check("t6_bad_perr", n_perr, 1);
    check("t6_bad_acc", n_acc, 6);
`else
    check("t6_perr_tied", n_perr, 0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
